// File: rtl/sysid_guard.sv
// sysid_guard -- boot-time System ID checker.
//
// Acts as a single-outstanding Avalon-MM read master in front of the SysID
// slave: reads word 0 (ID) and word 1 (build timestamp), compares them with
// compile-time expected values, retries the full sequence on mismatch and
// gives up on a bus that stalls for WAIT_TIMEOUT consecutive cycles.
//
// Configuration macro: SYSID_GUARD_TS_CHECK_EN
//   defined   -> both words are fetched and checked.
//   undefined -> only the ID word is checked; the timestamp read states are
//                compiled out, ts_value stays 0 and EXPECTED_TS is ignored.

module sysid_guard #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h6045_CFD0,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_CMP_ID,
    S_RD_TS,
    S_CMP_TS,
    S_PASS,
    S_FAIL
  } state_e;

  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_ID      = 2'b01;
  localparam logic [1:0]  ERR_TS      = 2'b10;
  localparam logic [1:0]  ERR_BUS     = 2'b11;
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
  // Last stalled count before the read is abandoned.
  localparam logic [15:0] WAIT_LAST   = 16'(WAIT_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        auto_q;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;

  logic timeout;
  logic retry_ok;
  logic id_match;
  logic launch;

  // Only meaningful in a read state: the read has been stalled long enough.
  assign timeout  = avm_waitrequest && (wait_cnt_q == WAIT_LAST);
  assign retry_ok = retry_cnt_q < RETRY_LIMIT;
  assign id_match = id_value_q == EXPECTED_ID;
  // start is honoured only while no check is in flight.
  assign launch   = start && (state_q == S_IDLE || state_q == S_PASS || state_q == S_FAIL);

`ifdef SYSID_GUARD_TS_CHECK_EN
  logic ts_match;
  assign ts_match = ts_value_q == EXPECTED_TS;
`else
  logic unused_expected_ts;
  assign unused_expected_ts = ^EXPECTED_TS;
`endif

  // State register; auto_q requests one check on the first post-reset cycle.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      auto_q  <= 1'b0;
    end
  end

  // Next-state logic.
  // NOTE: state_d is defaulted before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start || auto_q) state_d = S_RD_ID;
      end
      S_RD_ID: begin
        if (!avm_waitrequest) state_d = S_CMP_ID;
        else if (timeout)     state_d = S_FAIL;
      end
      S_CMP_ID: begin
        if (id_match) begin
`ifdef SYSID_GUARD_TS_CHECK_EN
          state_d = S_RD_TS;
`else
          state_d = S_PASS;
`endif
        end else begin
          state_d = retry_ok ? S_RD_ID : S_FAIL;
        end
      end
`ifdef SYSID_GUARD_TS_CHECK_EN
      S_RD_TS: begin
        if (!avm_waitrequest) state_d = S_CMP_TS;
        else if (timeout)     state_d = S_FAIL;
      end
      S_CMP_TS: begin
        if (ts_match) state_d = S_PASS;
        else          state_d = retry_ok ? S_RD_ID : S_FAIL;
      end
`endif
      S_PASS, S_FAIL: begin
        if (start) state_d = S_RD_ID;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered from these.
  always_comb begin
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    retry_cnt_d = retry_cnt_q;
    err_code_d  = err_code_q;
    wait_cnt_d  = '0;

    if (launch) begin
      retry_cnt_d = '0;
      err_code_d  = ERR_NONE;
    end

    case (state_q)
      S_RD_ID: begin
        if (!avm_waitrequest) id_value_d = avm_readdata;
        else if (timeout)     err_code_d = ERR_BUS;
        else                  wait_cnt_d = wait_cnt_q + 16'd1;
      end
      S_CMP_ID: begin
        if (!id_match) begin
          if (retry_ok) retry_cnt_d = retry_cnt_q + 4'd1;
          else          err_code_d  = ERR_ID;
        end
      end
`ifdef SYSID_GUARD_TS_CHECK_EN
      S_RD_TS: begin
        if (!avm_waitrequest) ts_value_d = avm_readdata;
        else if (timeout)     err_code_d = ERR_BUS;
        else                  wait_cnt_d = wait_cnt_q + 16'd1;
      end
      S_CMP_TS: begin
        if (!ts_match) begin
          if (retry_ok) retry_cnt_d = retry_cnt_q + 4'd1;
          else          err_code_d  = ERR_TS;
        end
      end
`endif
      default: ;
    endcase

    // Bus strobes and flags follow the state being entered so they line up
    // with that state's cycle despite being registered.
    avm_read_d = (state_d == S_RD_ID) || (state_d == S_RD_TS);
`ifdef SYSID_GUARD_TS_CHECK_EN
    // Address moves to word 1 once word 0 is captured, while read is low.
    avm_address_d = (state_d == S_CMP_ID) || (state_d == S_RD_TS);
`else
    avm_address_d = 1'b0;
`endif
    done_d = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d = state_d == S_PASS;
    fail_d = state_d == S_FAIL;
  end

  // Output and datapath registers.
  // NOTE: the captured data words are reset along with everything else, so a
  // reset during a read drops avm_read at once and leaves no partial capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q    <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      err_code_q    <= ERR_NONE;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      retry_cnt_q   <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      err_code_q    <= err_code_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      retry_cnt_q   <= retry_cnt_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_code    = err_code_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign retry_cnt   = retry_cnt_q;

endmodule

// File: tb/tb_sysid_guard.sv
// Testbench for sysid_guard (default parameters). Expected results are pushed
// into a scoreboard queue by the stimulus; a monitor pops and compares each
// time done rises. Adapts to SYSID_GUARD_TS_CHECK_EN being defined or not.

module tb_sysid_guard;

`ifdef SYSID_GUARD_TS_CHECK_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam logic [31:0] GOOD_TS = 32'h6045_CFD0;
  localparam logic [31:0] BAD_TS  = 32'h6045_CFD1;
  localparam logic [31:0] EXP_TS  = TS_EN ? GOOD_TS : 32'h0;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  err_code;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [3:0]  retry_cnt;

  always #5 clock = ~clock;

  sysid_guard dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .done            (done),
    .pass            (pass),
    .fail            (fail),
    .err_code        (err_code),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .retry_cnt       (retry_cnt)
  );

  // Scoreboard entry: result expected when done next rises.
  typedef struct {
    int          cyc;
    logic        pass;
    logic [1:0]  err;
    logic [3:0]  retry;
    logic [31:0] id;
    logic [31:0] ts;
    int          reads;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   addr_hi_cnt = 0;

  // Slave model controls: 0 no stall, 1 stall always, 2 stall word 1, 3 stall word 0.
  int          stall_mode = 0;
  bit          id_first_bad = 1'b0;
  bit          id_always_bad = 1'b0;
  logic [31:0] ts_word = GOOD_TS;
  int          id_reads;
  int          cyc;

  // Cycle counter (0 = reset release cycle) and completed word-0 reads.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc      <= 0;
      id_reads <= 0;
    end else begin
      cyc <= cyc + 1;
      if (avm_read && !avm_waitrequest && !avm_address) id_reads <= id_reads + 1;
    end
  end

  // Combinational SysID slave.
  always_comb begin
    avm_waitrequest = (stall_mode == 1) || (stall_mode == 2 && avm_address) ||
                      (stall_mode == 3 && !avm_address);
    if (avm_address)
      avm_readdata = ts_word;
    else if (id_always_bad || (id_first_bad && id_reads == 0))
      avm_readdata = 32'h0000_0001;
    else
      avm_readdata = 32'h0000_0000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int c, input logic p, input logic [1:0] e, input logic [3:0] r,
                      input logic [31:0] id, input logic [31:0] ts, input int reads);
    exp_t x;
    x.cyc = c; x.pass = p; x.err = e; x.retry = r; x.id = id; x.ts = ts; x.reads = reads;
    sb_q.push_back(x);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_avm_read"},  avm_read,    0);
    check({tag, "_avm_addr"},  avm_address, 0);
    check({tag, "_done"},      done,        0);
    check({tag, "_pass"},      pass,        0);
    check({tag, "_fail"},      fail,        0);
    check({tag, "_err_code"},  err_code,    0);
    check({tag, "_id_value"},  id_value,    0);
    check({tag, "_ts_value"},  ts_value,    0);
    check({tag, "_retry_cnt"}, retry_cnt,   0);
  endtask

  // Reset for a few cycles, release 1 time unit after a rising edge (cycle 0).
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Bounded wait for the monitor to consume every queued expectation.
  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    check({"drain_", name}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Monitor: compares on each rising done, tracks read cycles and address.
  initial begin
    bit   done_prev;
    bit   prev_stall;
    logic prev_addr;
    int   reads;
    exp_t e;
    done_prev = 1'b0; prev_stall = 1'b0; prev_addr = 1'b0; reads = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        done_prev  = 1'b0;
        prev_stall = 1'b0;
        reads      = 0;
      end else begin
        if (prev_stall && avm_read) check("addr_stable_in_stall", avm_address, prev_addr);
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        if (avm_read) reads++;
        if (avm_address) addr_hi_cnt++;
        if (done && !done_prev) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done_queue", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            check("done_cycle",  cyc,       e.cyc);
            check("pass",        pass,      e.pass);
            check("fail",        fail,      !e.pass);
            check("err_code",    err_code,  e.err);
            check("retry_cnt",   retry_cnt, e.retry);
            check("id_value",    id_value,  e.id);
            check("ts_value",    ts_value,  e.ts);
            check("read_cycles", reads,     e.reads);
          end
          reads = 0;
        end
        done_prev = done;
      end
    end
  end

  initial begin
    int c;

    // Reset values, then nominal auto-started check.
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("rst");
    push(TS_EN ? 5 : 3, 1'b1, 2'b00, 4'd0, 32'h0, EXP_TS, TS_EN ? 2 : 1);
    reset_n = 1'b1;
    check("idle_c0_avm_read", avm_read, 0);
    wait_drain(50, "nominal");

    // Word 0 wrong on the first read only: one ID retry (RD_ID+CMP_ID = 2 cycles).
    id_first_bad = 1'b1;
    push(TS_EN ? 7 : 5, 1'b1, 2'b00, 4'd1, 32'h0, EXP_TS, TS_EN ? 3 : 2);
    do_reset();
    wait_drain(50, "id_retry_once");
    id_first_bad = 1'b0;

`ifdef SYSID_GUARD_TS_CHECK_EN
    // Word 1 always wrong: four 4-cycle attempts, FAIL at cycle 17.
    ts_word = BAD_TS;
    push(17, 1'b0, 2'b10, 4'd3, 32'h0, BAD_TS, 8);
    do_reset();
    wait_drain(60, "ts_mismatch");
    ts_word = GOOD_TS;
`endif

    // Word 0 always wrong: CMP_ID at 2,4,6,8 -> FAIL at cycle 9.
    id_always_bad = 1'b1;
    push(9, 1'b0, 2'b01, 4'd3, 32'h1, 32'h0, 4);
    do_reset();
    wait_drain(50, "id_mismatch");
    repeat (5) @(posedge clock);
    #1;
    check("fail_sticky",  fail,     1);
    check("done_sticky",  done,     1);
    check("err_sticky",   err_code, 2'b01);

    // Relaunch from FAIL with start; a second start in CMP_ID is ignored.
    id_always_bad = 1'b0;
    @(negedge clock);
    c = cyc;
    push(c + (TS_EN ? 5 : 3), 1'b1, 2'b00, 4'd0, 32'h0, EXP_TS, TS_EN ? 2 : 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_drain(50, "relaunch");

    // waitrequest stuck high: read held 255 cycles, FAIL at cycle 256.
    stall_mode = 1;
    push(256, 1'b0, 2'b11, 4'd0, 32'h0, 32'h0, 255);
    do_reset();
    wait_drain(400, "bus_timeout");
    stall_mode = 0;

    // Reset asserted during a stalled read, then a clean rerun.
    stall_mode   = TS_EN ? 2 : 3;
    id_first_bad = TS_EN;
    do_reset();
    repeat (10) @(posedge clock);
    #2;
    check("pre_rst_avm_read",  avm_read,    1);
    check("pre_rst_avm_addr",  avm_address, TS_EN);
    check("pre_rst_retry_cnt", retry_cnt,   TS_EN);
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    stall_mode   = 0;
    id_first_bad = 1'b0;
    push(TS_EN ? 5 : 3, 1'b1, 2'b00, 4'd0, 32'h0, EXP_TS, TS_EN ? 2 : 1);
    do_reset();
    wait_drain(50, "rerun_after_reset");

`ifdef SYSID_GUARD_TS_CHECK_EN
    check("addr_word1_used", addr_hi_cnt != 0, 1);
`else
    check("addr_never_1", addr_hi_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
